// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings and width helpers.
package reset_seq_pkg;

  localparam int RETRY_W = 2;

  localparam logic [2:0] ST_ASSERT  = 3'd0;
  localparam logic [2:0] ST_RELEASE = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_REHOLD  = 3'd3;
  localparam logic [2:0] ST_RUN     = 3'd4;
  localparam logic [2:0] ST_FAIL    = 3'd5;

  function automatic int stage_w(input int n);
    return (n > 32'sd2) ? $clog2(n) : 32'sd1;
  endfunction

  function automatic int timer_w(input int hold_cycles, input int timeout_cycles);
    return $clog2((hold_cycles > timeout_cycles) ? hold_cycles : timeout_cycles) + 32'sd1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the blocks it brings up.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  import reset_seq_pkg::*;

  localparam int SW = stage_w(NUM_STAGES);

  logic                    soft_reset_req;
  logic [NUM_STAGES-1:0]   stage_done;
  logic [NUM_STAGES-1:0]   stage_resetn;
  logic                    seq_done;
  logic                    seq_error;
  logic [SW-1:0]           err_stage;
  logic [RETRY_W-1:0]      retry_count;
  logic                    lost_pulse;

  modport master (
    input  soft_reset_req, stage_done,
    output stage_resetn, seq_done, seq_error, err_stage, retry_count, lost_pulse
  );

  modport slave (
    output soft_reset_req, stage_done,
    input  stage_resetn, seq_done, seq_error, err_stage, retry_count, lost_pulse
  );

endinterface

// File: rtl/reset_sequencer_done_sync.sv
// Multi-flop synchronizer bringing the asynchronous per-stage done bits into sys_aclk.
module reset_done_sync #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] chain_q [SYNC_STAGES];

  // Shift the raw done bits through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        chain_q[i] <= '0;
      end
    end else begin
      chain_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered per-stage reset release with done-wait, timeout/retry, failure report and restart.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int HOLD_CYCLES    = 256,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 2,
  parameter int SYNC_STAGES    = 2
) (
  input  logic              sys_aclk,
  input  logic              sys_aresetn,
  reset_sequencer_if.master bus
);

  localparam int SW = stage_w(NUM_STAGES);
  localparam int TW = timer_w(HOLD_CYCLES, TIMEOUT_CYCLES);
  localparam int AW = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  // REHOLD exits one count early so the re-asserted stage is low exactly HOLD_CYCLES
  // cycles once the RELEASE cycle is included.
  localparam logic [TW-1:0] REHOLD_LAST = TW'(HOLD_CYCLES - 2);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] IDX_LAST    = SW'(NUM_STAGES - 1);
  localparam logic [AW-1:0] ATTEMPT_MAX = AW'(MAX_RETRY);

  logic [NUM_STAGES-1:0] ds;

  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [SW-1:0]         idx_q, idx_d;
  logic [AW-1:0]         attempt_q, attempt_d;
  logic [RETRY_W-1:0]    retry_q, retry_d;
  logic [NUM_STAGES-1:0] resetn_q, resetn_d;
  logic                  seq_done_q, seq_done_d;
  logic                  seq_error_q, seq_error_d;
  logic [SW-1:0]         err_stage_q, err_stage_d;
  logic                  lost_q, lost_d;

  reset_done_sync #(
    .WIDTH       (NUM_STAGES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_done_sync (
    .clk   (sys_aclk),
    .rst_n (sys_aresetn),
    .d     (bus.stage_done),
    .q     (ds)
  );

  // Next-state logic: soft reset first, then the sequencing FSM.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    attempt_d   = attempt_q;
    retry_d     = retry_q;
    resetn_d    = resetn_q;
    seq_done_d  = seq_done_q;
    seq_error_d = seq_error_q;
    err_stage_d = err_stage_q;
    lost_d      = 1'b0;

    if (bus.soft_reset_req) begin
      state_d     = ST_ASSERT;
      timer_d     = '0;
      idx_d       = '0;
      attempt_d   = '0;
      retry_d     = '0;
      resetn_d    = '0;
      seq_done_d  = 1'b0;
      seq_error_d = 1'b0;
      err_stage_d = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          resetn_d = '0;
          if (timer_q == HOLD_LAST) begin
            state_d = ST_RELEASE;
            timer_d = '0;
            idx_d   = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ST_RELEASE: begin
          resetn_d[idx_q] = 1'b1;
          timer_d         = '0;
          state_d         = ST_WAIT;
        end
        ST_WAIT: begin
          // Done on the timeout cycle still counts as success.
          if (ds[idx_q]) begin
            timer_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d    = ST_RUN;
              seq_done_d = 1'b1;
            end else begin
              idx_d     = idx_q + SW'(1);
              attempt_d = '0;
              retry_d   = '0;
              state_d   = ST_RELEASE;
            end
          end else if (timer_q == TMO_LAST) begin
            timer_d         = '0;
            resetn_d[idx_q] = 1'b0;
            if (attempt_q < ATTEMPT_MAX) begin
              attempt_d = attempt_q + AW'(1);
              retry_d   = (retry_q == RETRY_W'(3)) ? retry_q : retry_q + RETRY_W'(1);
              state_d   = ST_REHOLD;
            end else begin
              state_d     = ST_FAIL;
              seq_error_d = 1'b1;
              err_stage_d = idx_q;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ST_REHOLD: begin
          if (timer_q == REHOLD_LAST) begin
            state_d = ST_RELEASE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ST_RUN: begin
          if (!(&ds)) begin
            lost_d     = 1'b1;
            seq_done_d = 1'b0;
            resetn_d   = '0;
            attempt_d  = '0;
            retry_d    = '0;
            idx_d      = '0;
            timer_d    = '0;
            state_d    = ST_ASSERT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d    = ST_ASSERT;
          timer_d    = '0;
          idx_d      = '0;
          attempt_d  = '0;
          retry_d    = '0;
          resetn_d   = '0;
          seq_done_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge sys_aclk) begin
    if (!sys_aresetn) begin
      state_q     <= ST_ASSERT;
      timer_q     <= '0;
      idx_q       <= '0;
      attempt_q   <= '0;
      retry_q     <= '0;
      resetn_q    <= '0;
      seq_done_q  <= 1'b0;
      seq_error_q <= 1'b0;
      err_stage_q <= '0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      attempt_q   <= attempt_d;
      retry_q     <= retry_d;
      resetn_q    <= resetn_d;
      seq_done_q  <= seq_done_d;
      seq_error_q <= seq_error_d;
      err_stage_q <= err_stage_d;
      lost_q      <= lost_d;
    end
  end

  assign bus.stage_resetn = resetn_q;
  assign bus.seq_done     = seq_done_q;
  assign bus.seq_error    = seq_error_q;
  assign bus.err_stage    = err_stage_q;
  assign bus.retry_count  = retry_q;
  assign bus.lost_pulse   = lost_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scenario bench for reset_sequencer: stage_resetn edges are scoreboarded against cycle-exact expectations.
module tb_reset_sequencer;

  localparam int N  = 3;
  localparam int H  = 8;
  localparam int T  = 32;
  localparam int MR = 2;
  localparam int SS = 2;

  typedef struct packed {
    int           cyc;
    logic [N-1:0] val;
  } evt_t;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  int           cyc      = 0;
  int           lost_cnt = 0;
  int           checks   = 0;
  int           errors   = 0;
  int           c0;
  int           rd;
  logic [N-1:0] prev_resetn;
  evt_t         obs[$];
  evt_t         exp_q[$];

  reset_sequencer_if #(.NUM_STAGES(N)) bus ();

  reset_sequencer #(
    .NUM_STAGES     (N),
    .HOLD_CYCLES    (H),
    .TIMEOUT_CYCLES (T),
    .MAX_RETRY      (MR),
    .SYNC_STAGES    (SS)
  ) dut (
    .sys_aclk    (clk),
    .sys_aresetn (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every stage_resetn change and count lost pulses.
  always @(negedge clk) begin
    prev_resetn <= bus.stage_resetn;
    if (bus.stage_resetn !== prev_resetn) obs.push_back('{cyc: cyc, val: bus.stage_resetn});
    if (bus.lost_pulse === 1'b1) lost_cnt <= lost_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic apply_reset(input logic [N-1:0] done);
    rst_n = 1'b0;
    bus.soft_reset_req = 1'b0;
    bus.stage_done = done;
    step(3);
    rst_n = 1'b1;
    c0 = cyc;
    rd = obs.size();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.soft_reset_req = 1'b0;
    bus.stage_done = 3'b111;
    step(3);
    checks++;
    if (bus.stage_resetn !== 3'b000) begin
      errors++;
      $display("FAIL reset_resetn: got %b required 000", bus.stage_resetn);
    end
    checks++;
    if ({bus.seq_done, bus.seq_error, bus.lost_pulse} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got done/err/lost %b required 000", {bus.seq_done, bus.seq_error, bus.lost_pulse});
    end
    checks++;
    if ({bus.err_stage, bus.retry_count} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_counts: got err_stage %0d retry %0d required 0 0", bus.err_stage, bus.retry_count);
    end
  endtask

  task automatic test_nominal();
    evt_t e;
    apply_reset(3'b111);
    exp_q.push_back('{cyc: c0 + H + 1, val: 3'b001});
    exp_q.push_back('{cyc: c0 + H + 3, val: 3'b011});
    exp_q.push_back('{cyc: c0 + H + 5, val: 3'b111});
    step_to(c0 + H + 5);
    checks++;
    if (bus.seq_done !== 1'b0) begin
      errors++;
      $display("FAIL nominal_done_early: got %b required 0", bus.seq_done);
    end
    step(1);
    checks++;
    if ({bus.seq_done, bus.seq_error} !== 2'b10) begin
      errors++;
      $display("FAIL nominal_done: got done/err %b required 10", {bus.seq_done, bus.seq_error});
    end
    step(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd >= obs.size()) begin
        errors++;
        $display("FAIL nominal_edge: no change seen, required %b at +%0d", e.val, e.cyc - c0);
      end else if (obs[rd] !== e) begin
        errors++;
        $display("FAIL nominal_edge: got %b at +%0d required %b at +%0d", obs[rd].val, obs[rd].cyc - c0, e.val, e.cyc - c0);
        rd++;
      end else begin
        rd++;
      end
    end
    checks++;
    if (obs.size() != rd) begin
      errors++;
      $display("FAIL nominal_extra: got %0d extra edges required 0", obs.size() - rd);
    end
  endtask

  task automatic test_slow_stage();
    evt_t e;
    apply_reset(3'b101);
    exp_q.push_back('{cyc: c0 + 9,  val: 3'b001});
    exp_q.push_back('{cyc: c0 + 11, val: 3'b011});
    exp_q.push_back('{cyc: c0 + 35, val: 3'b111});
    step_to(c0 + 31);
    bus.stage_done = 3'b111;
    step_to(c0 + 36);
    checks++;
    if ({bus.seq_done, bus.retry_count} !== 3'b100) begin
      errors++;
      $display("FAIL slow_done: got done %b retry %0d required 1 0", bus.seq_done, bus.retry_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd >= obs.size()) begin
        errors++;
        $display("FAIL slow_edge: no change seen, required %b at +%0d", e.val, e.cyc - c0);
      end else if (obs[rd] !== e) begin
        errors++;
        $display("FAIL slow_edge: got %b at +%0d required %b at +%0d", obs[rd].val, obs[rd].cyc - c0, e.val, e.cyc - c0);
        rd++;
      end else begin
        rd++;
      end
    end
  endtask

  task automatic test_retry();
    evt_t e;
    apply_reset(3'b101);
    exp_q.push_back('{cyc: c0 + 9,  val: 3'b001});
    exp_q.push_back('{cyc: c0 + 11, val: 3'b011});
    exp_q.push_back('{cyc: c0 + 43, val: 3'b001});
    exp_q.push_back('{cyc: c0 + 51, val: 3'b011});
    exp_q.push_back('{cyc: c0 + 83, val: 3'b001});
    exp_q.push_back('{cyc: c0 + 91, val: 3'b011});
    exp_q.push_back('{cyc: c0 + 99, val: 3'b111});
    step_to(c0 + 50);
    checks++;
    if (bus.retry_count !== 2'd1) begin
      errors++;
      $display("FAIL retry_first: got %0d required 1", bus.retry_count);
    end
    step_to(c0 + 90);
    checks++;
    if (bus.retry_count !== 2'd2) begin
      errors++;
      $display("FAIL retry_second: got %0d required 2", bus.retry_count);
    end
    step_to(c0 + 95);
    bus.stage_done = 3'b111;
    step_to(c0 + 99);
    checks++;
    if (bus.seq_done !== 1'b0) begin
      errors++;
      $display("FAIL retry_done_early: got %b required 0", bus.seq_done);
    end
    step(1);
    checks++;
    if ({bus.seq_done, bus.seq_error} !== 2'b10) begin
      errors++;
      $display("FAIL retry_done: got done/err %b required 10", {bus.seq_done, bus.seq_error});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd >= obs.size()) begin
        errors++;
        $display("FAIL retry_edge: no change seen, required %b at +%0d", e.val, e.cyc - c0);
      end else if (obs[rd] !== e) begin
        errors++;
        $display("FAIL retry_edge: got %b at +%0d required %b at +%0d", obs[rd].val, obs[rd].cyc - c0, e.val, e.cyc - c0);
        rd++;
      end else begin
        rd++;
      end
    end
  endtask

  task automatic test_fail();
    evt_t e;
    int   cs;
    apply_reset(3'b011);
    exp_q.push_back('{cyc: c0 + 9,   val: 3'b001});
    exp_q.push_back('{cyc: c0 + 11,  val: 3'b011});
    exp_q.push_back('{cyc: c0 + 13,  val: 3'b111});
    exp_q.push_back('{cyc: c0 + 45,  val: 3'b011});
    exp_q.push_back('{cyc: c0 + 53,  val: 3'b111});
    exp_q.push_back('{cyc: c0 + 85,  val: 3'b011});
    exp_q.push_back('{cyc: c0 + 93,  val: 3'b111});
    exp_q.push_back('{cyc: c0 + 125, val: 3'b011});
    step_to(c0 + 124);
    checks++;
    if (bus.seq_error !== 1'b0) begin
      errors++;
      $display("FAIL fail_early: got seq_error %b required 0", bus.seq_error);
    end
    step(1);
    checks++;
    if ({bus.seq_error, bus.err_stage, bus.seq_done} !== 4'b1100) begin
      errors++;
      $display("FAIL fail_flags: got err %b stage %0d done %b required 1 2 0", bus.seq_error, bus.err_stage, bus.seq_done);
    end
    step(20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd >= obs.size()) begin
        errors++;
        $display("FAIL fail_edge: no change seen, required %b at +%0d", e.val, e.cyc - c0);
      end else if (obs[rd] !== e) begin
        errors++;
        $display("FAIL fail_edge: got %b at +%0d required %b at +%0d", obs[rd].val, obs[rd].cyc - c0, e.val, e.cyc - c0);
        rd++;
      end else begin
        rd++;
      end
    end
    checks++;
    if (obs.size() != rd || bus.stage_resetn !== 3'b011) begin
      errors++;
      $display("FAIL fail_hold: got resetn %b and %0d extra edges required 011 and 0", bus.stage_resetn, obs.size() - rd);
    end
    cs = cyc;
    exp_q.push_back('{cyc: cs + 1,  val: 3'b000});
    exp_q.push_back('{cyc: cs + 10, val: 3'b001});
    exp_q.push_back('{cyc: cs + 12, val: 3'b011});
    bus.soft_reset_req = 1'b1;
    step(1);
    bus.soft_reset_req = 1'b0;
    checks++;
    if ({bus.seq_error, bus.err_stage, bus.retry_count} !== 5'b00000) begin
      errors++;
      $display("FAIL fail_soft: got err %b stage %0d retry %0d required 0 0 0", bus.seq_error, bus.err_stage, bus.retry_count);
    end
    step_to(cs + 14);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd >= obs.size()) begin
        errors++;
        $display("FAIL fail_restart_edge: no change seen, required %b at +%0d", e.val, e.cyc - cs);
      end else if (obs[rd] !== e) begin
        errors++;
        $display("FAIL fail_restart_edge: got %b at +%0d required %b at +%0d", obs[rd].val, obs[rd].cyc - cs, e.val, e.cyc - cs);
        rd++;
      end else begin
        rd++;
      end
    end
  endtask

  task automatic test_lost();
    evt_t e;
    int   cd;
    int   base;
    apply_reset(3'b111);
    step_to(c0 + 20);
    cd   = cyc;
    base = lost_cnt;
    rd   = obs.size();
    exp_q.push_back('{cyc: cd + 3,  val: 3'b000});
    exp_q.push_back('{cyc: cd + 12, val: 3'b001});
    exp_q.push_back('{cyc: cd + 14, val: 3'b011});
    exp_q.push_back('{cyc: cd + 16, val: 3'b111});
    bus.stage_done = 3'b110;
    step(1);
    bus.stage_done = 3'b111;
    step(1);
    checks++;
    if (bus.lost_pulse !== 1'b0) begin
      errors++;
      $display("FAIL lost_early: got %b required 0", bus.lost_pulse);
    end
    step(1);
    checks++;
    if ({bus.lost_pulse, bus.seq_done} !== 2'b10) begin
      errors++;
      $display("FAIL lost_pulse: got lost/done %b required 10", {bus.lost_pulse, bus.seq_done});
    end
    step_to(cd + 17);
    checks++;
    if (lost_cnt - base != 1 || bus.seq_done !== 1'b1) begin
      errors++;
      $display("FAIL lost_count: got %0d pulses done %b required 1 1", lost_cnt - base, bus.seq_done);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd >= obs.size()) begin
        errors++;
        $display("FAIL lost_edge: no change seen, required %b at +%0d", e.val, e.cyc - cd);
      end else if (obs[rd] !== e) begin
        errors++;
        $display("FAIL lost_edge: got %b at +%0d required %b at +%0d", obs[rd].val, obs[rd].cyc - cd, e.val, e.cyc - cd);
        rd++;
      end else begin
        rd++;
      end
    end
  endtask

  task automatic test_mid_wait();
    int c1;
    int c2;
    int cd;
    int base;
    apply_reset(3'b101);
    step_to(c0 + 60);
    checks++;
    if ({bus.stage_resetn, bus.retry_count} !== 5'b01101) begin
      errors++;
      $display("FAIL midwait_pre: got resetn %b retry %0d required 011 1", bus.stage_resetn, bus.retry_count);
    end
    rst_n = 1'b0;
    step(1);
    checks++;
    if ({bus.stage_resetn, bus.retry_count, bus.seq_done, bus.seq_error, bus.lost_pulse} !== 8'd0) begin
      errors++;
      $display("FAIL midwait_hwreset: got resetn %b retry %0d done %b err %b required all 0", bus.stage_resetn, bus.retry_count, bus.seq_done, bus.seq_error);
    end
    rst_n = 1'b1;
    c1 = cyc;
    step_to(c1 + 60);
    bus.soft_reset_req = 1'b1;
    step(1);
    bus.soft_reset_req = 1'b0;
    checks++;
    if ({bus.stage_resetn, bus.retry_count, bus.seq_done, bus.seq_error} !== 7'd0) begin
      errors++;
      $display("FAIL midwait_soft: got resetn %b retry %0d done %b err %b required all 0", bus.stage_resetn, bus.retry_count, bus.seq_done, bus.seq_error);
    end
    bus.stage_done = 3'b111;
    c2 = cyc;
    step_to(c2 + 20);
    checks++;
    if (bus.seq_done !== 1'b1) begin
      errors++;
      $display("FAIL midwait_rerun: got seq_done %b required 1", bus.seq_done);
    end
    cd   = cyc;
    base = lost_cnt;
    bus.stage_done = 3'b110;
    step(1);
    bus.stage_done = 3'b111;
    step(1);
    bus.soft_reset_req = 1'b1;
    step(1);
    bus.soft_reset_req = 1'b0;
    checks++;
    if ({bus.lost_pulse, bus.stage_resetn, bus.seq_done} !== 5'b00000) begin
      errors++;
      $display("FAIL coincide_state: got lost %b resetn %b done %b required 0 000 0", bus.lost_pulse, bus.stage_resetn, bus.seq_done);
    end
    step_to(cd + 8);
    checks++;
    if (lost_cnt - base != 0) begin
      errors++;
      $display("FAIL coincide_lost: got %0d pulses required 0", lost_cnt - base);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_slow_stage();
    test_retry();
    test_fail();
    test_lost();
    test_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
